// File: rtl/div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle.
// Result word is {remainder, quotient}, handshaked with valid/done.
module div_seq #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           valid,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           done,
    output logic [2*W-1:0] c
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam logic [5:0] LAST = 6'(W - 1);

    state_t       state;
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [5:0]   cnt;

    logic [W:0]   r_sh;
    logic [W-1:0] r_sub;
    logic [W-1:0] r_nx;
    logic [W-1:0] q_nx;
    logic         ge;

    // The shifted remainder carries one extra bit so the compare cannot overflow.
    always_comb begin
        r_sh  = {r, q[W-1]};
        ge    = r_sh >= {1'b0, d};
        r_sub = r_sh[W-1:0] - d;
        r_nx  = ge ? r_sub : r_sh[W-1:0];
        q_nx  = {q[W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            done  <= 1'b0;
            c     <= '0;
            r     <= '0;
            q     <= '0;
            d     <= '0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        q     <= a;
                        d     <= b;
                        r     <= '0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!valid) begin
                        state <= IDLE;
                    end else begin
                        r <= r_nx;
                        q <= q_nx;
                        if (cnt == LAST) begin
                            c     <= {r_nx, q_nx};
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divides, abort, reset, back-to-back.
// Expected results are queued at issue and checked when done appears.
module tb_div_seq;

    typedef struct {
        int          cyc;
        logic [63:0] res;
        string       name;
    } exp_t;

    logic        clk;
    logic        resetn;
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        done;
    logic [63:0] c;

    exp_t sb[$];
    int   cyc;
    int   checks;
    int   errors;
    int   done_cnt;
    logic prev_done;

    div_seq #(.W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .valid  (valid),
        .a      (a),
        .b      (b),
        .done   (done),
        .c      (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check64(string nm, logic [63:0] got, logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Monitor: compare each done pulse against the head of the scoreboard.
    initial begin
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (prev_done) begin
                    errors++;
                    $display("FAIL done_twice cyc=%0d", cyc);
                end
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d c=%h", cyc, c);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checks++;
                    if (cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s_latency got_cyc=%0d want_cyc=%0d",
                                 e.name, cyc, e.cyc);
                    end
                    check64({e.name, "_result"}, c, e.res);
                end
            end
            prev_done = done;
        end
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(string nm, logic [31:0] x, logic [31:0] y,
                         logic [63:0] want, int lat);
        exp_t e;
        a     = x;
        b     = y;
        valid = 1'b1;
        e.cyc  = cyc + lat;
        e.res  = want;
        e.name = nm;
        sb.push_back(e);
    endtask

    // Full divide: valid stays high through the done cycle, dropped after.
    task automatic run(string nm, logic [31:0] x, logic [31:0] y,
                       logic [63:0] want);
        issue(nm, x, y, want, 33);
        step(5);
        a = 32'h1234_5678;
        b = 32'd3;
        step(29);
        valid = 1'b0;
        step(40);
    endtask

    initial begin
        int base;
        logic [63:0] held;
        checks   = 0;
        errors   = 0;
        done_cnt = 0;
        resetn   = 1'b0;
        valid    = 1'b0;
        a        = '0;
        b        = '0;
        step(3);
        check64("reset_c", c, 64'd0);
        check64("reset_done", {63'd0, done}, 64'd0);
        resetn = 1'b1;
        step(2);

        run("basic", 32'd100, 32'd7, {32'd2, 32'd14});
        run("max_by_1", 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});
        run("small_by_max", 32'd3, 32'hFFFF_FFFF, {32'd3, 32'd0});
        run("msb_by_msb", 32'h8000_0000, 32'h8000_0000, {32'd0, 32'd1});
        run("div_zero", 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF});
        run("by_16", 32'h1234_5678, 32'h10, {32'd8, 32'h0123_4567});

        base = done_cnt;
        issue("b2b_first", 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        step(33);
        a = 32'd9;
        b = 32'd2;
        begin
            exp_t e;
            e.cyc  = cyc + 34;
            e.res  = {32'd1, 32'd4};
            e.name = "b2b_second";
            sb.push_back(e);
        end
        step(35);
        valid = 1'b0;
        step(40);
        check64("b2b_pulses", 64'(done_cnt - base), 64'd2);

        held = c;
        base = done_cnt;
        a     = 32'd100;
        b     = 32'd7;
        valid = 1'b1;
        step(10);
        valid = 1'b0;
        step(40);
        check64("abort_no_done", 64'(done_cnt - base), 64'd0);
        check64("abort_c_kept", c, held);
        issue("after_abort", 32'd20, 32'd6, {32'd2, 32'd3}, 33);
        step(34);
        valid = 1'b0;
        step(40);

        base  = done_cnt;
        a     = 32'd100;
        b     = 32'd7;
        valid = 1'b1;
        step(15);
        resetn = 1'b0;
        valid  = 1'b0;
        step(1);
        check64("midreset_c", c, 64'd0);
        check64("midreset_done", {63'd0, done}, 64'd0);
        resetn = 1'b1;
        step(40);
        check64("midreset_no_done", 64'(done_cnt - base), 64'd0);

        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            errors++;
            $display("FAIL %s_missing want_cyc=%0d", e.name, e.cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
